// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared definitions for the instruction/data bus arbiter.
//   state_t          - arbiter FSM state encoding
//   CHIP_ENABLE/...  - memory chip-enable levels
//   TIMEOUT_DEFAULT  - default watchdog limit in SERVE cycles
//   SEL_WORD         - byte select used for full-word instruction fetches
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } state_t;

  localparam logic       CHIP_ENABLE     = 1'b1;
  localparam logic       CHIP_DISABLE    = 1'b0;
  localparam int         TIMEOUT_DEFAULT = 255;
  localparam logic [3:0] SEL_WORD        = 4'hF;

endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store port. Data accesses have fixed priority. Each
// transaction registers its request onto ram_*, waits for ram_ack_i and
// returns a one-cycle ack pulse; a watchdog aborts transactions that never
// complete so the pipeline cannot deadlock.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req_i / if_addr_i     fetch request (held until if_ack_o) and address
//   if_rdata_o / if_ack_o    fetched instruction and completion pulse
//   mem_req_i, mem_we_i      load/store request (held until mem_ack_o), 1=store
//   mem_addr_i, mem_wdata_i, mem_sel_i   load/store address, data, byte select
//   mem_rdata_o / mem_ack_o  load data and completion pulse
//   flush_i                  discard the fetch currently being served
//   ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_sel_o   shared memory port
//   ram_rdata_i, ram_ack_i   memory read data and completion (same cycle)
//   stallreq_o               combinational stall request to the pipeline
//   err_o                    sticky watchdog-timeout flag
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  input  logic        flush_i,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_sel_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_ack_i,
  output logic        stallreq_o,
  output logic        err_o
);

  // Abort fires at the end of the TIMEOUT-th SERVE cycle without an ack.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wdog_q;
  logic        discard_q;
  logic        mem_go, if_go, wdog_expired, fetch_drop;

  // A request whose ack is on the wire this cycle has already been served;
  // masking it here keeps it from being issued twice and yields the
  // one-cycle IDLE bubble between transactions.
  assign mem_go       = mem_req_i & ~mem_ack_o;
  assign if_go        = if_req_i & ~if_ack_o;
  assign wdog_expired = (wdog_q == WDOG_LAST);
  // A flush arriving in the completing cycle still suppresses the ack.
  assign fetch_drop   = discard_q | flush_i;

  assign stallreq_o = (mem_req_i & ~mem_ack_o) | (if_req_i & ~if_ack_o & ~flush_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_go)     state_d = SERVE_D;
        else if (if_go) state_d = SERVE_I;
      end
      SERVE_D, SERVE_I: begin
        if (ram_ack_i || wdog_expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the reset is sampled on the clock edge, and every register in this
  // block is cleared by it, outputs included, even mid-transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_ce_o    <= CHIP_DISABLE;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_sel_o   <= '0;
      if_rdata_o  <= '0;
      if_ack_o    <= 1'b0;
      mem_rdata_o <= '0;
      mem_ack_o   <= 1'b0;
      err_o       <= 1'b0;
      discard_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          wdog_q    <= '0;
          discard_q <= 1'b0;
          if (mem_go) begin
            ram_ce_o    <= CHIP_ENABLE;
            ram_we_o    <= mem_we_i;
            ram_addr_o  <= mem_addr_i;
            ram_wdata_o <= mem_wdata_i;
            ram_sel_o   <= mem_sel_i;
          end else if (if_go) begin
            ram_ce_o    <= CHIP_ENABLE;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= if_addr_i;
            ram_wdata_o <= '0;
            ram_sel_o   <= SEL_WORD;
          end
        end
        SERVE_D: begin
          if (ram_ack_i || wdog_expired) begin
            ram_ce_o  <= CHIP_DISABLE;
            wdog_q    <= '0;
            mem_ack_o <= 1'b1;
            if (!ram_ack_i) begin
              err_o       <= 1'b1;
              mem_rdata_o <= '0;
            end else if (!ram_we_o) begin
              mem_rdata_o <= ram_rdata_i;
            end
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        SERVE_I: begin
          if (ram_ack_i || wdog_expired) begin
            ram_ce_o  <= CHIP_DISABLE;
            wdog_q    <= '0;
            discard_q <= 1'b0;
            if (!ram_ack_i) err_o <= 1'b1;
            if (!fetch_drop) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= ram_ack_i ? ram_rdata_i : '0;
            end
          end else begin
            wdog_q <= wdog_q + 8'd1;
            if (flush_i) discard_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios followed by randomized traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_rdata = '0;
  logic [3:0]  mem_sel = '0;
  logic        ram_ack = 1'b0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ack, mem_ack, ram_ce, ram_we, stallreq, err;
  logic [3:0]  ram_sel;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel),
    .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack), .flush_i(flush),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_sel_o(ram_sel),
    .ram_rdata_i(ram_rdata), .ram_ack_i(ram_ack),
    .stallreq_o(stallreq), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus the visible
  // results of the last completed one.
  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          waited;
    bit          dropped;
  } txn_t;

  bit          busy = 0;
  txn_t        cur;
  bit          m_if_ack = 0, m_mem_ack = 0, m_err = 0;
  logic [31:0] m_if_rdata = '0, m_mem_rdata = '0;

  task automatic model_tick();
    bit          was_if_ack, was_mem_ack, timed;
    logic [31:0] data;
    was_if_ack  = m_if_ack;
    was_mem_ack = m_mem_ack;
    m_if_ack    = 0;
    m_mem_ack   = 0;
    if (rst) begin
      busy = 0; m_err = 0; m_if_rdata = '0; m_mem_rdata = '0;
    end else if (!busy) begin
      if (mem_req && !was_mem_ack) begin
        busy = 1;
        cur = '{is_data: 1, we: mem_we, addr: mem_addr, wdata: mem_wdata,
                sel: mem_sel, waited: 0, dropped: 0};
      end else if (if_req && !was_if_ack) begin
        busy = 1;
        cur = '{is_data: 0, we: 0, addr: if_addr, wdata: '0, sel: 4'hF,
                waited: 0, dropped: 0};
      end
    end else begin
      if (!cur.is_data && flush) cur.dropped = 1;
      timed = !ram_ack && (cur.waited + 1 == TO);
      if (ram_ack || timed) begin
        busy = 0;
        data = timed ? 32'h0 : ram_rdata;
        if (timed) m_err = 1;
        if (cur.is_data) begin
          m_mem_ack = 1;
          if (timed || !cur.we) m_mem_rdata = data;
        end else if (!cur.dropped) begin
          m_if_ack   = 1;
          m_if_rdata = data;
        end
      end else begin
        cur.waited++;
      end
    end
  endtask

  // One clock: check the combinational stall against current inputs, advance
  // the model, then compare all registered outputs after the edge.
  task automatic step();
    #1;
    check("stallreq", stallreq,
          (mem_req & ~m_mem_ack) | (if_req & ~m_if_ack & ~flush));
    model_tick();
    @(posedge clk);
    #1;
    check("if_ack", if_ack, m_if_ack);
    check("mem_ack", mem_ack, m_mem_ack);
    check("if_rdata", if_rdata, m_if_rdata);
    check("mem_rdata", mem_rdata, m_mem_rdata);
    check("err", err, m_err);
    check("ram_ce", ram_ce, busy);
    if (busy) begin
      check("ram_we", ram_we, cur.we);
      check("ram_addr", ram_addr, cur.addr);
      if (cur.is_data) begin
        check("ram_wdata", ram_wdata, cur.wdata);
        check("ram_sel", ram_sel, cur.sel);
      end
    end
    @(negedge clk);
  endtask

  int          ce_cnt = 0;
  int          ack_delay = 0;

  initial begin
    @(negedge clk);
    // Reset, then a fetch sampled in the very first cycle out of reset.
    step(); step();
    check("rst_ce", ram_ce, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 0; if_req = 1; if_addr = 32'h100;
    step();
    check("f_ce", ram_ce, 1'b1);
    check("f_addr", ram_addr, 32'h100);
    ram_ack = 1; ram_rdata = 32'h3C010001;
    step();
    ram_ack = 0;
    check("f_ack", if_ack, 1'b1);
    check("f_data", if_rdata, 32'h3C010001);
    if_req = 0;
    step();

    // Simultaneous load and fetch: data first, one bubble, then the fetch.
    mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_sel = 4'hF;
    if_req = 1; if_addr = 32'h100;
    step();
    check("pr_addr", ram_addr, 32'h200);
    ram_ack = 1; ram_rdata = 32'h11112222;
    step();
    ram_ack = 0;
    check("pr_mack", mem_ack, 1'b1);
    check("pr_mdata", mem_rdata, 32'h11112222);
    check("pr_bubble", ram_ce, 1'b0);
    mem_req = 0;
    step();
    check("pr_faddr", ram_addr, 32'h100);
    ram_ack = 1; ram_rdata = 32'h22223333;
    step();
    ram_ack = 0;
    check("pr_fack", if_ack, 1'b1);
    if_req = 0;
    step();

    // Store: held stable over wait cycles, load data untouched.
    mem_req = 1; mem_we = 1; mem_addr = 32'h204; mem_wdata = 32'hDEADBEEF; mem_sel = 4'hF;
    step(); step(); step();
    check("sw_we", ram_we, 1'b1);
    check("sw_wdata", ram_wdata, 32'hDEADBEEF);
    ram_ack = 1; ram_rdata = 32'h55555555;
    step();
    ram_ack = 0;
    check("sw_ack", mem_ack, 1'b1);
    check("sw_keep", mem_rdata, 32'h11112222);
    mem_req = 0; mem_we = 0;
    step();

    // Flush during a fetch: no ack, then the refetch completes normally.
    if_req = 1; if_addr = 32'h300;
    step();
    flush = 1;
    step();
    flush = 0; if_addr = 32'h304; ram_ack = 1; ram_rdata = 32'h77;
    step();
    ram_ack = 0;
    check("fl_noack", if_ack, 1'b0);
    step();
    check("fl_addr", ram_addr, 32'h304);
    ram_ack = 1; ram_rdata = 32'h88;
    step();
    ram_ack = 0;
    check("fl_ack", if_ack, 1'b1);
    check("fl_data", if_rdata, 32'h88);
    if_req = 0;
    step();

    // Withheld ack: abort after TO SERVE cycles with zero data.
    mem_req = 1; mem_addr = 32'h400;
    step();
    for (int i = 0; i < TO - 1; i++) step();
    check("to_wait", ram_ce, 1'b1);
    step();
    check("to_ack", mem_ack, 1'b1);
    check("to_data", mem_rdata, 32'h0);
    check("to_err", err, 1'b1);
    mem_req = 0;
    step(); step();
    check("to_sticky", err, 1'b1);

    // Reset mid-load, then a late ram_ack in IDLE is ignored.
    mem_req = 1; mem_addr = 32'h500;
    step();
    rst = 1;
    step();
    rst = 0; mem_req = 0;
    check("rs_ce", ram_ce, 1'b0);
    check("rs_err", err, 1'b0);
    check("rs_addr", ram_addr, 32'h0);
    ram_ack = 1;
    step();
    ram_ack = 0;
    check("rs_late", mem_ack, 1'b0);
    step();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (mem_ack) begin
        mem_req = $urandom_range(0, 1);
        mem_we = $urandom_range(0, 1); mem_addr = $urandom;
        mem_wdata = $urandom; mem_sel = 4'($urandom_range(0, 15));
      end else if (!mem_req && $urandom_range(0, 3) == 0) begin
        mem_req = 1;
        mem_we = $urandom_range(0, 1); mem_addr = $urandom;
        mem_wdata = $urandom; mem_sel = 4'($urandom_range(0, 15));
      end
      if (if_ack) begin
        if_req = $urandom_range(0, 1); if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      flush = ($urandom_range(0, 9) == 0);
      if (flush && if_req) if_addr = $urandom;
      ram_rdata = $urandom;
      if (ram_ce) begin
        if (ce_cnt == 0) ack_delay = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 2);
        ram_ack = (ce_cnt == ack_delay);
        ce_cnt++;
      end else begin
        ce_cnt = 0;
        ram_ack = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
